// File: rtl/mode_counter_pkg.sv
// Shared types and constants for the mode_counter timer/counter.
//   state_t      : FSM encoding (IDLE, RUN, DONE)
//   MODE_*       : mode_i encodings (auto-reload / one-shot)
//   DIR_*        : dir_i encodings (up / down)
package mode_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_RELOAD  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mode_counter_prescaler.sv
// Clock-enable divider: emits a tick every div_i+1 enabled cycles.
//   clk_i  : clock
//   rst_i  : synchronous active-low reset
//   clr_i  : restart the division (wins over en_i, suppresses the tick)
//   en_i   : advance enable
//   div_i  : divide value minus one
//   tick_o : combinational tick, valid in the cycle the count wraps
module prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] r_pcnt;
  logic [PRESC_W-1:0] w_pcnt_n;
  logic               w_wrap;

  assign w_wrap = (r_pcnt == div_i);
  assign tick_o = en_i && !clr_i && w_wrap;

  // Next prescaler count
  always_comb begin
    w_pcnt_n = r_pcnt;
    if (clr_i) begin
      w_pcnt_n = '0;
    end else if (en_i) begin
      w_pcnt_n = w_wrap ? '0 : r_pcnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_pcnt <= '0;
    else        r_pcnt <= w_pcnt_n;
  end

endmodule

// File: rtl/mode_counter.sv
// General-purpose timer/counter: up/down, programmable terminal value,
// prescaled tick, one-shot or auto-reload, parallel load, sticky flags.
//   clk_i, rst_i (sync active-low)
//   en_i, dir_i, mode_i, start_i, stop_i, limit_i, presc_i : control/config
//   load_i, load_val_i : parallel load
//   clr_flag_i         : clear done_o/ovf_o
//   counter_o, tc_o, done_o, ovf_o, busy_o : registered status
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               dir_i,
  input  logic               mode_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [WIDTH-1:0]   limit_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   load_val_i,
  input  logic               clr_flag_i,
  output logic [WIDTH-1:0]   counter_o,
  output logic               tc_o,
  output logic               done_o,
  output logic               ovf_o,
  output logic               busy_o
);

  state_t             r_state, w_state_n;
  logic [WIDTH-1:0]   r_cnt, w_cnt_n;
  logic [WIDTH-1:0]   r_limit, w_limit_n;
  logic [PRESC_W-1:0] r_presc, w_presc_n;
  logic               r_dir, w_dir_n;
  logic               r_mode, w_mode_n;
  logic               r_tc, w_tc_n;
  logic               r_done, w_done_n;
  logic               r_ovf, w_ovf_n;
  logic               r_busy;
  logic               w_tick;
  logic               w_at_term;
  logic               w_term_ev;

  // Prescaler only advances in RUN; start and load restart it
  prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (load_i || start_i),
    .en_i   (en_i && (r_state == RUN)),
    .div_i  (r_presc),
    .tick_o (w_tick)
  );

  assign w_at_term = (r_dir == DIR_UP) ? (r_cnt == r_limit) : (r_cnt == '0);

  // Next-state, counter and flag logic; priority load > stop > start > tick
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_limit_n = r_limit;
    w_presc_n = r_presc;
    w_dir_n   = r_dir;
    w_mode_n  = r_mode;
    w_term_ev = 1'b0;
    w_done_n  = r_done;
    w_ovf_n   = r_ovf;

    if (load_i) begin
      w_cnt_n = load_val_i;
    end else if (stop_i) begin
      w_state_n = IDLE;
    end else if (start_i) begin
      w_dir_n   = dir_i;
      w_mode_n  = mode_i;
      w_limit_n = limit_i;
      w_presc_n = presc_i;
      w_cnt_n   = (dir_i == DIR_UP) ? '0 : limit_i;
      w_state_n = RUN;
    end else if (w_tick) begin
      if (w_at_term) begin
        w_term_ev = 1'b1;
        if (r_mode == MODE_RELOAD) w_cnt_n = (r_dir == DIR_UP) ? '0 : r_limit;
        else                       w_state_n = DONE;
      end else begin
        // Plain modular step; wrapping through zero is not a terminal event
        w_cnt_n = (r_dir == DIR_UP) ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
      end
    end

    // A terminal event coinciding with a flag clear leaves done set, ovf clear
    if (w_term_ev) begin
      w_ovf_n  = clr_flag_i ? 1'b0 : (r_ovf || r_done);
      w_done_n = 1'b1;
    end else if (clr_flag_i) begin
      w_done_n = 1'b0;
      w_ovf_n  = 1'b0;
    end

    w_tc_n = w_term_ev;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_limit <= '0;
      r_presc <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_limit <= w_limit_n;
      r_presc <= w_presc_n;
      r_dir   <= w_dir_n;
      r_mode  <= w_mode_n;
      r_tc    <= w_tc_n;
      r_done  <= w_done_n;
      r_ovf   <= w_ovf_n;
      r_busy  <= (w_state_n == RUN);
    end
  end

  assign counter_o = r_cnt;
  assign tc_o      = r_tc;
  assign done_o    = r_done;
  assign ovf_o     = r_ovf;
  assign busy_o    = r_busy;

endmodule

// File: doc/mode_counter.md
Name: mode_counter

Overview:
- Parametrised successor of the team's fixed 16-bit enable counter.
- Adds configurable width, up/down direction, programmable terminal value, prescaler, one-shot or auto-reload mode, parallel load, and sticky done/overflow flags.
- Intended as the general-purpose timer/counter for the Vivado flow example designs; sits directly on the fabric clock and feeds status LEDs or an interrupt line.

Parameters:
WIDTH, 16, counter and limit width (>=2)
PRESC_W, 8, prescaler width

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-low reset
en_i  in  1  count enable; gates the prescaler (pause when low)
dir_i  in  1  1 = count up, 0 = count down; sampled on start
mode_i  in  1  0 = auto-reload, 1 = one-shot; sampled on start
start_i  in  1  arm/restart counting
stop_i  in  1  abort to IDLE
limit_i  in  WIDTH  terminal value; sampled on start
presc_i  in  PRESC_W  tick every presc_i+1 enabled cycles; sampled on start
load_i  in  1  parallel load strobe
load_val_i  in  WIDTH  value written on load_i
clr_flag_i  in  1  clear done_o and ovf_o
counter_o  out  WIDTH  current count
tc_o  out  1  one-cycle terminal-count pulse
done_o  out  1  sticky: terminal reached
ovf_o  out  1  sticky: terminal reached while done_o already set
busy_o  out  1  high in RUN

Behaviour:
- Reset is synchronous, active-low (rst_i == 0 at a rising edge of clk_i). All outputs go to 0, FSM goes to IDLE, prescaler and latched configuration go to 0.
- FSM states: IDLE, RUN, DONE. busy_o = (state == RUN).
- Event priority per cycle: reset > load_i > stop_i > start_i > tick.
- start_i (no load/stop):
  - Latches dir/mode/limit/presc and clears the prescaler.
  - Sets counter_o = 0 (up) or limit (down).
  - Next state RUN from any state; restarts if already in RUN.
- stop_i: next state IDLE; counter_o holds.
- load_i: counter_o <= load_val_i and prescaler <= 0. State is unchanged and no tick occurs that cycle. A loaded value beyond limit in up mode counts up to 2^WIDTH-1, wraps to 0, then continues to limit; the modular wrap does not raise tc_o.
- Prescaler, in RUN only:
  - When en_i = 1: pcnt increments; when pcnt == presc_lat, pcnt <= 0 and tick = 1.
  - When en_i = 0: pcnt and counter hold.
  - presc_lat = 0 means a tick on every enabled cycle.
- Tick, counter not at terminal: counter ±1, modulo 2^WIDTH.
- Tick, counter at terminal (up: == limit; down: == 0):
  - tc_o = 1 on the next cycle (registered, aligned with the updated counter_o).
  - done_o <= 1.
  - ovf_o <= 1 if done_o was already 1.
  - Auto-reload: counter reloads (up: 0, down: limit) and the FSM stays in RUN.
  - One-shot: counter holds at terminal and the FSM goes to DONE.
- limit = 0: every tick is terminal. Up mode reads 0 continuously with tc_o pulsing each tick.
- clr_flag_i clears done_o and ovf_o. If a terminal event occurs in the same cycle, done_o = 1 and ovf_o = 0.
- IDLE and DONE: counter holds, no ticks. start_i from DONE re-arms.
- Latency: start_i at edge N gives counter = start value at N+1. The first count change occurs presc+1 enabled cycles after start.
- Reset mid-RUN: everything returns to reset values on the next edge; flags are lost.

Decomposition:
- Package mode_counter_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t
  - mode constants MODE_RELOAD = 1'b0 and MODE_ONESHOT = 1'b1
  - direction constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0
- One sub-module, prescaler (parameter PRESC_W; ports clk_i, rst_i, clr_i, en_i, div_i, tick_o), instantiated once.
- FSM, counter and flags stay in mode_counter.

Test Plan:
- Reset with rst_i = 0 for 2 cycles mid-RUN at count 0x1234 -> counter_o = 0, all flags 0, busy_o = 0 on the next edge.
- Up, reload, limit = 4, presc = 0, en_i = 1, start -> counter 0,1,2,3,4,0,1...; tc_o pulses with each 0 after 4; second pulse sets ovf_o.
- Down, one-shot, limit = 3, presc = 2 -> counter 3,2,1,0, each held 3 cycles; tc_o once; state DONE, busy_o = 0, counter stays 0; later start_i restarts at 3.
- en_i toggled 1,0,1,0 with presc = 1 -> counter advances only after 2 enabled cycles; holds while en_i = 0.
- load_i = 1 with load_val_i = 0xFFFE and start_i = 1 in the same cycle, up, limit = 0x10 -> counter 0xFFFE (load wins, start ignored). A following start_i gives 0x0000; re-run with a load of 0xFFFE during RUN -> 0xFFFF, 0x0000 with no tc_o, then tc_o at 0x10.
- Terminal event and clr_flag_i in the same cycle with done_o = 1 -> done_o = 1, ovf_o = 0; clr_flag_i alone the next cycle -> both 0.
